// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: controller states, adder
// operation encoding and the Booth bit-pair decode.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } booth_state_e;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    ADD = 2'b01,
    SUB = 2'b10
  } booth_op_e;

  // Partial-product register enables; at most one bit set per cycle.
  typedef struct packed {
    logic ld;
    logic pp;
    logic fp;
  } booth_en_t;

  // {q0, q-1}: 01 -> add multiplicand, 10 -> subtract, 00/11 -> shift only.
  function automatic booth_op_e booth_decode(input logic [1:0] bits);
    booth_op_e op;
    case (bits)
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Remaining-iteration counter: load WIDTH_IN, count down, flag the last pass.
module booth_iter_counter #(
  parameter  int WIDTH_IN = 16,
  localparam int CNT_W    = $clog2(WIDTH_IN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!reset || clear)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(WIDTH_IN);
    else if (dec)
      cnt <= cnt - CNT_W'(1);
  end

  assign last = (cnt == CNT_W'(1));

  // The FSM leaves ITER on the last pass, so a decrement at zero means a
  // sequencing bug.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (dec && !clear && !load) |-> (cnt != '0));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-2 Booth multiplier: load, WIDTH_IN
// add/sub/shift passes, final capture, then a valid/ready hand-off.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int WIDTH_IN = 16,
  localparam int CNT_W    = $clog2(WIDTH_IN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic             start_rdy_o,
  input  logic [1:0]       booth_bits_i,
  input  logic             flush_i,
  output logic             en_i,
  output logic             en_pp,
  output logic             en_fp,
  output logic [1:0]       op_o,
  output logic [CNT_W-1:0] iter_cnt_o,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i
);

  booth_state_e state_q, state_d;
  booth_en_t    en;
  booth_op_e    op;
  logic         last;

  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (last) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything but reset, including a pending product.
    if (flush_i)
      state_d = IDLE;
  end

  always_comb begin
    en    = '0;
    en.ld = (state_q == LOAD);
    en.pp = (state_q == ITER);
    en.fp = (state_q == FINAL);
  end

  // op_o is the only output that looks at an input; gated so the adder
  // idles outside the iteration window.
  assign op = (state_q == ITER) ? booth_decode(booth_bits_i) : NOP;

  booth_iter_counter #(.WIDTH_IN(WIDTH_IN)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (flush_i),
    .load  (en.ld),
    .dec   (en.pp),
    .cnt   (iter_cnt_o),
    .last  (last)
  );

  assign en_i        = en.ld;
  assign en_pp       = en.pp;
  assign en_fp       = en.fp;
  assign op_o        = op;
  assign start_rdy_o = (state_q == IDLE);
  assign busy_o      = (state_q == LOAD) || (state_q == ITER) || (state_q == FINAL);
  assign valid_o     = (state_q == DONE);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Cycle-level bench for booth_seq_ctrl: vector table plus multi-cycle
// sequences, with a queue tracking when each accepted start must yield valid.
module tb_booth_seq_ctrl;
  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset, start_i, flush_i, ready_i;
  logic [1:0]    booth_bits_i;
  logic          start_rdy_o, en_i, en_pp, en_fp, busy_o, valid_o;
  logic [1:0]    op_o;
  logic [CW-1:0] iter_cnt_o;

  booth_seq_ctrl #(.WIDTH_IN(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .start_rdy_o  (start_rdy_o),
    .booth_bits_i (booth_bits_i),
    .flush_i      (flush_i),
    .en_i         (en_i),
    .en_pp        (en_pp),
    .en_fp        (en_fp),
    .op_o         (op_o),
    .iter_cnt_o   (iter_cnt_o),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy, ei, epp, efp;
    logic [1:0]    op;
    logic          busy, valid;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic       rst, start, flush, ready;
    logic [1:0] bits;
    exp_t       e;
    string      nm;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   sb[$];
  logic prev_valid = 1'b0;

  function automatic logic [1:0] ref_op(input logic [1:0] b);
    return (b == 2'b01) ? 2'b01 : (b == 2'b10) ? 2'b10 : 2'b00;
  endfunction

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Expected outputs k cycles after the start was accepted (k=0 is IDLE).
  function automatic exp_t exp_at(input int k, input logic [1:0] b);
    exp_t e = '0;
    if (k == 0) e.rdy = 1'b1;
    else if (k == 1) begin e.ei = 1'b1; e.busy = 1'b1; end
    else if (k <= W + 1) begin
      e.epp = 1'b1; e.busy = 1'b1; e.op = ref_op(b); e.cnt = CW'(W + 2 - k);
    end
    else if (k == W + 2) begin e.efp = 1'b1; e.busy = 1'b1; end
    else e.valid = 1'b1;
    return e;
  endfunction

  function automatic vec_t mkv(input logic rst, st, fl, rd, input logic [1:0] b,
                               input exp_t e, input string nm);
    vec_t v;
    v.rst = rst; v.start = st; v.flush = fl; v.ready = rd; v.bits = b; v.e = e; v.nm = nm;
    return v;
  endfunction

  task automatic cyc(input logic rst, st, fl, rd, input logic [1:0] b,
                     input exp_t e, input string nm);
    exp_t act;
    @(negedge clk);
    reset = rst; start_i = st; flush_i = fl; ready_i = rd; booth_bits_i = b;
    #1;
    act = {start_rdy_o, en_i, en_pp, en_fp, op_o, busy_o, valid_o, iter_cnt_o};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got rdy/ei/epp/efp/op/busy/valid/cnt=%b want %b",
               nm, cyc_no, act, e);
    end
    if (valid_o && !prev_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_valid cyc %0d: got valid rise want no pending product", cyc_no);
      end else begin
        int t = sb.pop_front();
        if (t != cyc_no) begin
          errors++;
          $display("FAIL sb_latency: got valid at cyc %0d want cyc %0d", cyc_no, t);
        end
      end
    end
    prev_valid = valid_o;
    if (!rst || fl) sb.delete();
    else if (st && e.rdy) sb.push_back(cyc_no + W + 3);
    cyc_no++;
  endtask

  task automatic run_mult(input int from, input int to, input string nm);
    for (int k = from; k <= to; k++) begin
      logic [1:0] b = 2'($urandom_range(3));
      cyc(1'b1, k == 0, 1'b0, 1'b1, b, exp_at(k, b), nm);
    end
  endtask

  initial begin
    vec_t       tbl[12];
    logic [1:0] b;
    reset = 1'b0; start_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1; booth_bits_i = 2'b01;
    repeat (2) @(posedge clk);

    // Reset, IDLE op gating, decode of all four bit pairs, mid-ITER flush.
    tbl[0]  = mkv(0, 1, 0, 1, 2'b01, idle_e(),         "reset_state");
    tbl[1]  = mkv(1, 0, 0, 1, 2'b01, idle_e(),         "idle_op_gate");
    tbl[2]  = mkv(1, 0, 0, 1, 2'b10, idle_e(),         "idle_op_gate2");
    tbl[3]  = mkv(1, 1, 0, 1, 2'b11, idle_e(),         "tbl_start");
    tbl[4]  = mkv(1, 0, 0, 1, 2'b01, exp_at(1, 2'b01), "tbl_load");
    tbl[5]  = mkv(1, 0, 0, 1, 2'b00, exp_at(2, 2'b00), "dec_00");
    tbl[6]  = mkv(1, 0, 0, 1, 2'b01, exp_at(3, 2'b01), "dec_01");
    tbl[7]  = mkv(1, 0, 0, 1, 2'b10, exp_at(4, 2'b10), "dec_10");
    tbl[8]  = mkv(1, 0, 0, 1, 2'b11, exp_at(5, 2'b11), "dec_11");
    tbl[9]  = mkv(1, 1, 1, 1, 2'b01, exp_at(6, 2'b01), "tbl_flush");
    tbl[10] = mkv(1, 0, 0, 1, 2'b10, idle_e(),         "tbl_flush_idle");
    tbl[11] = mkv(1, 0, 0, 1, 2'b01, idle_e(),         "tbl_idle");
    for (int i = 0; i < 12; i++)
      cyc(tbl[i].rst, tbl[i].start, tbl[i].flush, tbl[i].ready, tbl[i].bits, tbl[i].e, tbl[i].nm);

    // Back-to-back multiplies with ready held high.
    run_mult(0, W + 3, "mult_a");
    run_mult(0, W + 3, "mult_b");
    cyc(1, 0, 0, 1, 2'b01, idle_e(), "mult_idle");

    // Backpressure with ignored starts in DONE.
    run_mult(0, W + 2, "bp_run");
    for (int i = 0; i < 5; i++) begin
      b = 2'($urandom_range(3));
      cyc(1, i[0] == 1'b0, 0, 0, b, exp_at(W + 3, b), "bp_hold");
    end
    cyc(1, 1, 0, 1, 2'b10, exp_at(W + 3, 2'b10), "bp_release");
    cyc(1, 0, 0, 1, 2'b01, idle_e(), "bp_idle");
    cyc(1, 0, 0, 1, 2'b01, idle_e(), "bp_no_queued_start");

    // Flush in cycle 8 of a multiply, then a full clean multiply.
    run_mult(0, 7, "abort_run");
    cyc(1, 0, 1, 1, 2'b01, exp_at(8, 2'b01), "abort_flush");
    cyc(1, 0, 0, 1, 2'b01, idle_e(), "abort_idle");
    run_mult(0, W + 3, "abort_rerun");

    // Flush in DONE drops the pending product.
    run_mult(0, W + 2, "fdone_run");
    cyc(1, 0, 1, 0, 2'b00, exp_at(W + 3, 2'b00), "flush_done");
    cyc(1, 0, 0, 0, 2'b00, idle_e(), "flush_done_idle");

    // Reset in cycle 10, held with start high for two cycles.
    run_mult(0, 9, "rst_run");
    b = 2'b10;
    cyc(0, 1, 0, 1, b, exp_at(10, b), "rst_mid");
    cyc(0, 1, 0, 1, b, idle_e(), "rst_held");
    cyc(1, 0, 0, 1, b, idle_e(), "rst_start_ignored");
    cyc(1, 0, 0, 1, b, idle_e(), "rst_idle");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending products want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Sequencing controller for the radix-2 Booth multiplier datapath.
- Accepts a multiply request and drives the partial-product register's load (en_i), iterate (en_pp) and final-capture (en_fp) enables.
- Decodes the Booth bit pair into add/sub/nop for the adder stage, counts WIDTH_IN iterations, and presents the result through a valid/ready handshake.

Parameters:
- WIDTH_IN, 16, multiplier operand width; equals the number of Booth iterations.
- CNT_W, $clog2(WIDTH_IN+1), iteration counter width; localparam, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start_i  in  1  request a multiply; operands stable on the datapath inputs this cycle
- start_rdy_o  out  1  controller idle; start_i is accepted only when this is 1
- booth_bits_i  in  2  partial-product bits {pp[1], pp[0]} = {q0, q-1}
- flush_i  in  1  synchronous abort to IDLE
- en_i  out  1  load the partial-product register with the initial value
- en_pp  out  1  update the partial-product register with the adder/shift result
- en_fp  out  1  capture the final product
- op_o  out  2  Booth operation: 00 NOP, 01 ADD, 10 SUB; 11 is never driven
- iter_cnt_o  out  CNT_W  remaining iterations (debug/verification visibility)
- busy_o  out  1  operation in progress (LOAD, ITER or FINAL)
- valid_o  out  1  product available in the final register
- ready_i  in  1  consumer accepts the product

Behaviour:
- Reset: reset==0 at a clk edge forces state IDLE and iter_cnt=0.
- Outputs after reset: en_i, en_pp, en_fp, busy_o, valid_o and op_o all 0; start_rdy_o=1.
- Reset mid-operation abandons the operation with no en_fp and no valid_o.
- Reset has priority over flush_i, and flush_i has priority over every other input.
- States are IDLE, LOAD, ITER, FINAL and DONE. All outputs are decoded from state, except op_o.
- IDLE:
  - start_rdy_o=1.
  - start_i=1 moves to LOAD; otherwise stays in IDLE.
- LOAD:
  - en_i=1 for exactly one cycle.
  - iter_cnt loads WIDTH_IN.
  - Next state is ITER.
- ITER:
  - en_pp=1 every cycle.
  - op_o is decoded combinationally from booth_bits_i: 00→NOP, 11→NOP, 01→ADD, 10→SUB.
  - iter_cnt decrements every cycle.
  - When iter_cnt==1, the next state is FINAL, so ITER lasts exactly WIDTH_IN cycles.
- FINAL: en_fp=1 for one cycle; next state is DONE.
- DONE:
  - valid_o=1, held until ready_i=1.
  - Once valid_o is raised, it and the product stay stable until accepted.
  - valid_o && ready_i moves to IDLE. A new start is accepted no earlier than the following cycle.
- op_o is 00 in every state other than ITER, regardless of booth_bits_i.
- The enables are one-hot or all-zero: at most one of en_i, en_pp and en_fp is 1 in any cycle.
- Start rules:
  - start_i outside IDLE is ignored, not queued.
  - start_rdy_o is 0 in all non-IDLE states.
- Latency: with start_i accepted in cycle 0:
  - en_i is high in cycle 1.
  - en_pp is high in cycles 2 .. WIDTH_IN+1.
  - en_fp is high in cycle WIDTH_IN+2.
  - valid_o is first high in cycle WIDTH_IN+3 (cycle 19 for the default).
- Throughput: one product per WIDTH_IN+4 cycles when ready_i is held at 1.
- flush_i:
  - Next state is IDLE and iter_cnt=0.
  - A flush in DONE drops the pending product; valid_o falls next cycle.
- busy_o = state ∈ {LOAD, ITER, FINAL}.
- iter_cnt_o:
  - Equals iter_cnt.
  - Never wraps below 0; a decrement at 0 is unreachable. An assertion checks it.

Decomposition:
- Shared package booth_pkg:
  - booth_state_e enum (IDLE, LOAD, ITER, FINAL, DONE).
  - booth_op_e enum (NOP=2'b00, ADD=2'b01, SUB=2'b10).
  - The decode function booth_decode(bits) → booth_op_e, reused by the datapath's adder-select logic and the bench model.
- Sub-module: booth_iter_counter (load/decrement/clear counter with a last flag) is natural; the FSM stays in booth_seq_ctrl.

Test Plan:
- Reset check: reset held low 3 cycles, then released.
  - Expect start_rdy_o=1, all enables and valid_o=0, op_o=00, iter_cnt_o=0.
- Single multiply, WIDTH_IN=16: start_i pulse in cycle 0, ready_i=1.
  - Expect en_i in cycle 1, en_pp in cycles 2–17 (16 cycles), en_fp in cycle 18, valid_o in cycle 19 only, start_rdy_o=1 in cycle 20.
- Booth decode: during ITER drive booth_bits_i 00, 01, 10, 11.
  - Expect op_o 00, 01, 10, 00.
  - In IDLE with booth_bits_i=01, expect op_o=00.
- Backpressure: ready_i=0 for 5 cycles after valid_o rises.
  - Expect valid_o held 5 cycles with no enables.
  - start_i pulses during DONE are ignored.
  - ready_i=1 returns to IDLE.
- Abort: flush_i in cycle 8 (mid-ITER).
  - Expect IDLE next cycle, no en_fp, no valid_o, iter_cnt_o=0.
  - A subsequent start completes normally with the full 16 en_pp cycles.
- Reset mid-operation: reset=0 in cycle 10.
  - Expect all outputs 0 and start_rdy_o=1 from the next cycle.
  - start_i asserted while reset=0 is ignored.
